reflet_conv_arbiter: RTL and testbench

REFLET_CONV_ARBITER -- requirements
Module: reflet_conv_arbiter

---
 rtl/reflet_conv_arbiter.sv | 115 +++++++++++
 tb/tb_reflet_conv_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_conv_arbiter.sv
// Two-requester arbiter sharing one combinational int16 -> float32 converter.
// Each conversion takes accept -> convert -> hold, so at most one result per 3 cycles.

module reflet_int_to_float (
   input  logic [15:0] int_i,
   output logic [31:0] float_o
);
   logic        sign;
   logic [15:0] mag;
   logic [3:0]  msb;
   logic [3:0]  shamt;
   logic [15:0] norm;
   logic [7:0]  expo;

   always_comb begin
      sign  = int_i[15];
      // Magnitude of -32768 is 0x8000, which still fits in 16 unsigned bits.
      mag   = sign ? (~int_i + 16'd1) : int_i;
      msb   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (mag[i]) msb = 4'(i);
      end
      shamt = 4'd15 - msb;
      norm  = mag << shamt;
      expo  = 8'd127 + {4'd0, msb};
      if (mag == 16'd0) float_o = 32'd0;
      else              float_o = {sign, expo, norm[14:0], 8'd0};
   end
endmodule

module reflet_conv_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [15:0] req0_int,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_int,
   output logic        req1_ready,
   output logic        res_valid,
   output logic [31:0] res_float,
   output logic        res_id,
   input  logic        res_ready,
   output logic        busy
);
   typedef enum logic [1:0] {StIdle, StConvert, StHold} state_e;

   state_e      state_q;
   logic [15:0] op_q;
   logic        id_q;
   logic        last_grant_q;
   logic        res_valid_q;
   logic [31:0] res_float_q;
   logic        res_id_q;

   logic        grant_any;
   logic        grant_id;
   logic [31:0] float_out;

   reflet_int_to_float u_conv (
      .int_i   (op_q),
      .float_o (float_out)
   );

   always_comb begin
      grant_any = (state_q == StIdle) && (req0_valid || req1_valid);
      if (req0_valid && req1_valid) grant_id = ROUND_ROBIN ? ~last_grant_q : 1'b0;
      else                          grant_id = !req0_valid;
      req0_ready = reset && grant_any && !grant_id;
      req1_ready = reset && grant_any && grant_id;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         op_q         <= 16'd0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         res_valid_q  <= 1'b0;
         res_float_q  <= 32'd0;
         res_id_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  op_q         <= grant_id ? req1_int : req0_int;
                  id_q         <= grant_id;
                  last_grant_q <= grant_id;
                  state_q      <= StConvert;
               end
            end
            StConvert: begin
               res_float_q <= float_out;
               res_id_q    <= id_q;
               res_valid_q <= 1'b1;
               state_q     <= StHold;
            end
            StHold: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign res_float = res_float_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != StIdle);
endmodule

// File: tb/tb_reflet_conv_arbiter.sv
// Scoreboard bench: directed requests push expected results, monitors pop on each handshake.

module tb_reflet_conv_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        r0v, r1v, r0r, r1r, rv, rid, rrdy, busy;
   logic [15:0] r0i, r1i;
   logic [31:0] rf;
   logic        f0v, f1v, f0r, f1r, frv, fid, frdy, fbusy;
   logic [15:0] f0i, f1i;
   logic [31:0] ff;

   int chk_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int rv_seen = 0;
   int fp_cnt = 0;
   bit fp_on = 1'b0;
   logic [32:0] exp_q[$];

   reflet_conv_arbiter #(.ROUND_ROBIN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0v), .req0_int(r0i), .req0_ready(r0r),
      .req1_valid(r1v), .req1_int(r1i), .req1_ready(r1r),
      .res_valid(rv), .res_float(rf), .res_id(rid), .res_ready(rrdy), .busy(busy)
   );

   reflet_conv_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .req0_valid(f0v), .req0_int(f0i), .req0_ready(f0r),
      .req1_valid(f1v), .req1_int(f1i), .req1_ready(f1r),
      .res_valid(frv), .res_float(ff), .res_id(fid), .res_ready(frdy), .busy(fbusy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Main monitor: pops the scoreboard on each result handshake.
   always @(negedge clk) begin
      if (reset && rv) begin
         rv_seen++;
         if (rrdy) begin
            if (exp_q.size() == 0) begin
               check("unexpected result", rf, 32'hxxxxxxxx);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("res_float", rf, e[31:0]);
               check("res_id", {31'd0, rid}, {31'd0, e[32]});
            end
         end
      end
   end

   // Fixed-priority monitor: requester 1 must never win, every result is 1.0 from id 0.
   always @(negedge clk) begin
      if (fp_on) begin
         check("fp req1_ready", {31'd0, f1r}, 32'd0);
         if (frv) begin
            fp_cnt++;
            check("fp res_float", ff, 32'h3F800000);
            check("fp res_id", {31'd0, fid}, 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int who, input logic [15:0] op, output int gcyc);
      bit got;
      got = 1'b0;
      gcyc = -1;
      if (who == 0) begin r0v = 1'b1; r0i = op; end
      else          begin r1v = 1'b1; r1i = op; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((who == 0 && r0r) || (who == 1 && r1r)) begin
            got  = 1'b1;
            gcyc = cyc;
         end
      end
      check("grant seen", {31'd0, got}, 32'd1);
      tick();
      if (who == 0) r0v = 1'b0;
      else          r1v = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 32'd0);
      tick();
   endtask

   initial begin
      int g1, g2, seen;
      bit first_r0, got;
      reset = 1'b0; rrdy = 1'b1;
      r0v = 1'b1; r0i = 16'd7; r1v = 1'b0; r1i = 16'd0;
      f0v = 1'b0; f0i = 16'd0; f1v = 1'b0; f1i = 16'd0; frdy = 1'b1;
      @(negedge clk);
      check("ready0 in reset", {31'd0, r0r}, 32'd0);
      tick(); tick();
      r0v = 1'b0;
      @(negedge clk);
      check("reset res_valid", {31'd0, rv}, 32'd0);
      check("reset res_float", rf, 32'd0);
      check("reset res_id", {31'd0, rid}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Both valid right after reset: req0 first, then req1.
      exp_q.push_back({1'b0, 32'h43060000});
      exp_q.push_back({1'b1, 32'hC5581000});
      r0v = 1'b1; r0i = 16'd134; r1v = 1'b1; r1i = 16'hF27F;
      got = 1'b0; first_r0 = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (r0r || r1r) begin
            got = 1'b1; first_r0 = r0r;
            check("single ready", {31'd0, r1r}, 32'd0);
         end
      end
      check("rr first is req0", {31'd0, first_r0}, 32'd1);
      tick();
      r0v = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (r1r) got = 1'b1;
      end
      check("rr second is req1", {31'd0, got}, 32'd1);
      tick();
      r1v = 1'b0;
      drain();

      // Single operand -6 with latency checks.
      exp_q.push_back({1'b0, 32'hC0C00000});
      req(0, 16'hFFFA, g1);
      @(negedge clk);
      check("N+1 res_valid", {31'd0, rv}, 32'd0);
      check("N+1 busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("N+2 res_valid", {31'd0, rv}, 32'd1);
      @(negedge clk);
      check("N+3 res_valid", {31'd0, rv}, 32'd0);
      check("N+3 busy", {31'd0, busy}, 32'd0);
      tick();

      // Operand 0 held for 5 cycles; a new valid must be ignored meanwhile.
      rrdy = 1'b0;
      exp_q.push_back({1'b0, 32'h00000000});
      exp_q.push_back({1'b1, 32'h40A00000});
      req(0, 16'd0, g1);
      r1v = 1'b1; r1i = 16'd5;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold res_valid", {31'd0, rv}, 32'd1);
         check("hold res_float", rf, 32'd0);
         check("hold busy", {31'd0, busy}, 32'd1);
         check("hold ignores req1", {31'd0, r1r}, 32'd0);
      end
      tick();
      rrdy = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("idle after release", {31'd0, busy}, 32'd0);
      check("req1 granted in idle", {31'd0, r1r}, 32'd1);
      tick();
      r1v = 1'b0;
      drain();

      // Reset during CONVERT discards the in-flight -32768.
      seen = rv_seen;
      req(0, 16'h8000, g1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("flush res_valid", {31'd0, rv}, 32'd0);
      check("flush res_float", rf, 32'd0);
      check("flush busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("flush no valid", rv_seen, seen);
      tick();
      exp_q.push_back({1'b0, 32'h3F800000});
      req(0, 16'd1, g1);
      drain();

      // Extremes back to back: grants exactly 3 cycles apart.
      exp_q.push_back({1'b0, 32'hC7000000});
      exp_q.push_back({1'b0, 32'h46FFFE00});
      req(0, 16'h8000, g1);
      req(0, 16'h7FFF, g2);
      check("grant spacing", g2 - g1, 32'd3);
      drain();

      // Fixed priority instance with both valid continuously.
      f0v = 1'b1; f0i = 16'd1; f1v = 1'b1; f1i = 16'hFFFF;
      fp_on = 1'b1;
      repeat (13) @(negedge clk);
      fp_on = 1'b0;
      tick();
      f0v = 1'b0; f1v = 1'b0;
      check("fp result count", {31'd0, fp_cnt >= 3}, 32'd1);
      repeat (4) tick();
      check("final scoreboard", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end
endmodule
